// File: rtl/pipe_arb_pkg.sv
// Shared types for the packet-granular PipeInLast arbiter.
package pipe_arb_pkg;

  localparam int MAX_NREQ = 16;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

endpackage

// File: rtl/pipe_last_buf.sv
// One-entry PipeInLast register stage: a beat loaded here is offered downstream
// on the next cycle, and a drain and a reload in the same cycle keep full rate.
module pipe_last_buf #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_v,
  input  logic             load_last,
  input  logic             rdy,
  output logic             valid,
  output logic             ena,
  output logic [WIDTH-1:0] v,
  output logic             last,
  output logic             space
);

  assign ena   = valid & rdy;
  assign space = ~valid | rdy;

  always_ff @(posedge CLK) begin
    if (!nRST)
      valid <= 1'b0;
    else if (load)
      valid <= 1'b1;
    else if (ena)
      valid <= 1'b0;
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge CLK) begin
    if (load) begin
      v    <= load_v;
      last <= load_last;
    end
  end

endmodule

// File: rtl/pipe_last_arbiter.sv
// Round-robin arbiter sharing one PipeInLast sink; a grant is held from the
// first beat of a packet until its last beat has been accepted.
module pipe_last_arbiter
  import pipe_arb_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 32,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       in_req,
  input  logic [NREQ-1:0]       in_enq__ENA,
  input  logic [NREQ*WIDTH-1:0] in_enq_v,
  input  logic [NREQ-1:0]       in_enq_last,
  output logic [NREQ-1:0]       in_enq__RDY,
  output logic                  out_enq__ENA,
  output logic [WIDTH-1:0]      out_enq_v,
  output logic                  out_enq_last,
  input  logic                  out_enq__RDY,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  arb_state_t       state;
  logic [IDW-1:0]   gid;
  logic [IDW-1:0]   rr_ptr;
  logic             space;
  logic             valid;
  logic             accept;
  logic [WIDTH-1:0] sel_v;
  logic             sel_last;
  logic [NREQ-1:0]  rdy_vec;

  // Rotate so the requester after ptr sits at bit 0, take the lowest set bit,
  // then rotate the index back.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [IDW-1:0]  ptr);
    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  k;
    logic            found;
    int              j;
    rot   = '0;
    k     = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j      = (int'(ptr) + 1 + i) % NREQ;
      rot[i] = req[j[IDW-1:0]];
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        k     = IDW'(i);
        found = 1'b1;
      end
    end
    j = (int'(k) + int'(ptr) + 1) % NREQ;
    return j[IDW-1:0];
  endfunction

  always_comb begin
    rdy_vec = '0;
    if (state == ARB_LOCKED && space)
      rdy_vec[gid] = 1'b1;
  end

  assign in_enq__RDY = rdy_vec;
  assign accept      = in_enq__ENA[gid] & rdy_vec[gid];
  assign sel_v       = in_enq_v[gid*WIDTH +: WIDTH];
  assign sel_last    = in_enq_last[gid];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= ARB_IDLE;
      gid    <= '0;
      rr_ptr <= IDW'(NREQ - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|in_req) begin
            gid   <= rr_pick(in_req, rr_ptr);
            state <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (accept && sel_last) begin
            rr_ptr <= gid;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  pipe_last_buf #(.WIDTH(WIDTH)) u_buf (
    .CLK       (CLK),
    .nRST      (nRST),
    .load      (accept),
    .load_v    (sel_v),
    .load_last (sel_last),
    .rdy       (out_enq__RDY),
    .valid     (valid),
    .ena       (out_enq__ENA),
    .v         (out_enq_v),
    .last      (out_enq_last),
    .space     (space)
  );

  assign grant_id = gid;
  assign busy     = (state == ARB_LOCKED) | valid;

  // A strobe on a port that is not ready is dropped by the datapath above.
  always_ff @(posedge CLK) begin
    if (nRST)
      assert ((in_enq__ENA & ~rdy_vec) == '0)
        else $error("pipe_last_arbiter: enq strobe without ready ena=%b rdy=%b", in_enq__ENA, rdy_vec);
  end

endmodule
